// File: rtl/spi_ram_responder.sv
// SPI mode-0 target emulating the program RAM: READ 0x03 / WRITE 0x02 + 16-bit address, plus a parallel load port.
// Define SPI_RESP_FAST_READ_EN to accept FAST_READ 0x0B (8 dummy clocks before data).
module spi_ram_responder #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] INIT_BYTE = 8'h77
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic              cmd_err
);
    localparam int SR_W = (ADDR_W > 8) ? ADDR_W : 8;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_RDATA, ST_WDATA, ST_IGNORE
`ifdef SPI_RESP_FAST_READ_EN
        , ST_DUMMY
`endif
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sck_s1, r_sck_s2, r_sck_s3;
    logic              r_cs_s1, r_cs_s2, r_cs_s3;
    logic              r_mosi_s1, r_mosi_s2;
    logic [4:0]        r_bit_cnt;
    logic [SR_W-1:0]   r_shift_in;
    logic [7:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_shift_out;
    logic              r_miso, r_miso_oe, r_cmd_err, r_rd_load;
    logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

    logic              w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic [SR_W-1:0]   w_shift_nxt;
    logic [7:0]        w_byte_in;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_spi_we, w_cmd_bad;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_s3;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_s3;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;
    assign w_shift_nxt = {r_shift_in[SR_W-2:0], r_mosi_s2};
    assign w_byte_in   = w_shift_nxt[7:0];
    assign w_addr_inc  = r_addr + 1'b1;
    assign w_spi_we    = !w_cs_rise && (r_state == ST_WDATA) && w_sck_rise && (r_bit_cnt == 5'd7);

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign busy        = ~r_cs_s2;
    assign cmd_err     = r_cmd_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_sck_s1, r_sck_s2, r_sck_s3} <= 3'b000;
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= 3'b111;
            {r_mosi_s1, r_mosi_s2}         <= 2'b00;
        end else begin
            {r_sck_s1, r_sck_s2, r_sck_s3} <= {spi_sck, r_sck_s1, r_sck_s2};
            {r_cs_s1, r_cs_s2, r_cs_s3}    <= {spi_cs_n, r_cs_s1, r_cs_s2};
            {r_mosi_s1, r_mosi_s2}         <= {spi_mosi, r_mosi_s1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_bad   = 1'b0;
        if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (w_sck_rise && r_bit_cnt == 5'd7) begin
                        case (w_byte_in)
                            8'h02, 8'h03: w_state_nxt = ST_ADDR;
`ifdef SPI_RESP_FAST_READ_EN
                            8'h0B:        w_state_nxt = ST_ADDR;
`endif
                            default: begin
                                w_state_nxt = ST_IGNORE;
                                w_cmd_bad   = 1'b1;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise && r_bit_cnt == 5'd15) begin
                        if (r_cmd == 8'h02)      w_state_nxt = ST_WDATA;
`ifdef SPI_RESP_FAST_READ_EN
                        else if (r_cmd == 8'h0B) w_state_nxt = ST_DUMMY;
`endif
                        else                     w_state_nxt = ST_RDATA;
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                ST_DUMMY: if (w_sck_rise && r_bit_cnt == 5'd7) w_state_nxt = ST_RDATA;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_shift_out <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_rd_load   <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_bad;
            r_rd_load <= 1'b0;
            if (w_cs_rise || r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                if (w_sck_rise) begin
                    r_shift_in <= w_shift_nxt;
                    r_bit_cnt  <= r_bit_cnt + 5'd1;
                end
                case (r_state)
                    ST_CMD: begin
                        if (w_sck_rise && r_bit_cnt == 5'd7) begin
                            r_cmd     <= w_byte_in;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_ADDR: begin
                        if (w_sck_rise && r_bit_cnt == 5'd15) begin
                            r_addr    <= w_shift_nxt[ADDR_W-1:0];
                            r_bit_cnt <= '0;
                            r_rd_load <= (w_state_nxt == ST_RDATA);
                        end
                    end
`ifdef SPI_RESP_FAST_READ_EN
                    ST_DUMMY: begin
                        if (w_sck_rise && r_bit_cnt == 5'd7) begin
                            r_bit_cnt <= '0;
                            r_rd_load <= 1'b1;
                        end
                    end
`endif
                    // A fall with no rise yet in this byte (trailing edge of the
                    // previous phase) must not shift, or bit 7 would be skipped.
                    ST_RDATA: begin
                        if (r_rd_load) begin
                            r_shift_out <= r_mem[r_addr];
                            r_miso      <= r_mem[r_addr][7];
                            r_miso_oe   <= 1'b1;
                        end else if (w_sck_fall && r_bit_cnt == 5'd8) begin
                            r_addr      <= w_addr_inc;
                            r_shift_out <= r_mem[w_addr_inc];
                            r_miso      <= r_mem[w_addr_inc][7];
                            r_bit_cnt   <= '0;
                        end else if (w_sck_fall && r_bit_cnt != 5'd0) begin
                            r_shift_out <= {r_shift_out[6:0], 1'b0};
                            r_miso      <= r_shift_out[6];
                        end
                    end
                    ST_WDATA: begin
                        if (w_sck_rise && r_bit_cnt == 5'd7) begin
                            r_addr    <= w_addr_inc;
                            r_bit_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << ADDR_W); i++) r_mem[i] <= INIT_BYTE;
        end else if (w_spi_we) begin
            r_mem[r_addr] <= w_byte_in;
        end else if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end
endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: an SPI initiator with randomized timing drives transactions; a byte-array model predicts read data.
`timescale 1ns/1ps
module tb_spi_ram_responder;
    localparam int ADDR_W = 8;
    localparam int MEM_N  = 1 << ADDR_W;
`ifdef SPI_RESP_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              spi_cs_n = 1'b1;
    logic              spi_sck = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [7:0]        load_data = '0;
    logic              spi_miso, spi_miso_oe, busy, cmd_err;

    int         n_checks = 0;
    int         n_errors = 0;
    int         err_pulses = 0;
    bit         mon_en = 1'b0;
    logic [7:0] model_mem [MEM_N];
    logic [7:0] rx_buf [16];
    logic [7:0] tx_buf [16];

    always #5 clk = ~clk;

    spi_ram_responder #(.ADDR_W(ADDR_W), .INIT_BYTE(8'h77)) dut (
        .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy), .cmd_err(cmd_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every-cycle monitor: busy is cs_n seen through two clock stages, MISO idles low.
    initial begin
        logic cs_h1, cs_h2, prev_busy, prev_err;
        cs_h1 = 1'b1; cs_h2 = 1'b1; prev_busy = 1'b0; prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", 32'(busy), 32'(!cs_h2));
                check("miso_undriven", 32'(spi_miso && !spi_miso_oe), 32'd0);
                if (!busy && !prev_busy) check("oe_idle", 32'(spi_miso_oe), 32'd0);
                check("cmd_err_width", 32'(cmd_err && prev_err), 32'd0);
                if (cmd_err) err_pulses++;
            end
            cs_h2 = cs_h1;
            cs_h1 = spi_cs_n;
            prev_busy = busy;
            prev_err = cmd_err;
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output int oe_cnt);
        rx = '0;
        oe_cnt = 0;
        for (int b = 7; b > 7 - nbits; b--) begin
            spi_mosi = tx[b];
            wait_clks($urandom_range(4, 7));
            rx[b] = spi_miso;
            if (spi_miso_oe) oe_cnt++;
            spi_sck = 1'b1;
            wait_clks($urandom_range(4, 7));
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr);
        logic [7:0] rx;
        int         oc;
        spi_cs_n = 1'b0;
        wait_clks(4);
        spi_bits(cmd, 8, rx, oc);
        spi_bits(addr[15:8], 8, rx, oc);
        spi_bits(addr[7:0], 8, rx, oc);
    endtask

    task automatic cs_end();
        wait_clks(4);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(8);
    endtask

    task automatic spi_read(input logic [15:0] addr, input int n, input bit fast);
        logic [7:0]        rx;
        int                oc;
        logic [ADDR_W-1:0] a;
        err_pulses = 0;
        send_hdr(fast ? 8'h0B : 8'h03, addr);
        if (fast) spi_bits(8'h00, 8, rx, oc);
        a = addr[ADDR_W-1:0];
        for (int i = 0; i < n; i++) begin
            spi_bits(8'($urandom), 8, rx, oc);
            rx_buf[i] = rx;
            check("read_data", 32'(rx), 32'(model_mem[a]));
            check("read_oe_bits", 32'(oc), 32'd8);
            a = a + 1'b1;
        end
        cs_end();
        check("oe_after", 32'(spi_miso_oe), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("read_cmd_err", 32'(err_pulses), 32'd0);
    endtask

    // Writes tx_buf[0..n-1], then optionally a partial byte that must be dropped.
    task automatic spi_write(input logic [15:0] addr, input int n, input int part_bits);
        logic [7:0]        rx;
        int                oc;
        logic [ADDR_W-1:0] a;
        err_pulses = 0;
        send_hdr(8'h02, addr);
        a = addr[ADDR_W-1:0];
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, rx, oc);
            model_mem[a] = tx_buf[i];
            a = a + 1'b1;
        end
        if (part_bits > 0) spi_bits(8'($urandom), part_bits, rx, oc);
        cs_end();
        check("write_cmd_err", 32'(err_pulses), 32'd0);
    endtask

    task automatic spi_bad(input logic [7:0] cmd, input int extra);
        logic [7:0] rx;
        int         oc;
        int         total;
        err_pulses = 0;
        total = 0;
        spi_cs_n = 1'b0;
        wait_clks(4);
        spi_bits(cmd, 8, rx, oc);
        for (int i = 0; i < extra; i++) begin
            spi_bits(8'($urandom), 8, rx, oc);
            total += oc;
        end
        cs_end();
        check("ignore_oe_bits", 32'(total), 32'd0);
        check("bad_cmd_err_pulses", 32'(err_pulses), 32'd1);
    endtask

    task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        wait_clks(1);
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    initial begin
        logic [7:0] c;
        int         op;
        for (int i = 0; i < MEM_N; i++) model_mem[i] = 8'h77;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(3);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        mon_en = 1'b1;

        spi_read(16'h0000, 1, 1'b0);
        check("init_byte", 32'(rx_buf[0]), 32'h77);

        load_byte(8'h10, 8'hA5);
        load_byte(8'h11, 8'h3C);
        spi_read(16'h0010, 2, 1'b0);
        check("load_rd0", 32'(rx_buf[0]), 32'hA5);
        check("load_rd1", 32'(rx_buf[1]), 32'h3C);

        tx_buf[0] = 8'h12;
        tx_buf[1] = 8'h34;
        spi_write(16'h00FF, 2, 0);
        spi_read(16'h00FF, 2, 1'b0);
        check("wrap_rd0", 32'(rx_buf[0]), 32'h12);
        check("wrap_rd1", 32'(rx_buf[1]), 32'h34);

        spi_bad(8'h9F, 2);
        spi_read(16'h0011, 1, 1'b0);
        check("after_bad_rd", 32'(rx_buf[0]), 32'h3C);

        spi_write(16'h0020, 0, 5);
        spi_read(16'h0020, 1, 1'b0);
        check("abort_wr_rd", 32'(rx_buf[0]), 32'h77);

        if (FAST_EN) begin
            spi_read(16'h0010, 1, 1'b1);
            check("fast_rd", 32'(rx_buf[0]), 32'hA5);
        end else begin
            spi_bad(8'h0B, 1);
        end

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: spi_read(16'($urandom), $urandom_range(1, 4), FAST_EN && ($urandom_range(0, 1) == 1));
                1: begin
                    for (int i = 0; i < 4; i++) tx_buf[i] = 8'($urandom);
                    spi_write(16'($urandom), $urandom_range(1, 4), 0);
                end
                2: load_byte(ADDR_W'($urandom), 8'($urandom));
                3: begin
                    do c = 8'($urandom);
                    while (c == 8'h02 || c == 8'h03 || (FAST_EN && c == 8'h0B));
                    spi_bad(c, $urandom_range(0, 2));
                end
                default: begin
                    for (int i = 0; i < 4; i++) tx_buf[i] = 8'($urandom);
                    spi_write(16'($urandom), $urandom_range(0, 2), $urandom_range(1, 7));
                end
            endcase
        end

        for (int i = 0; i < 8; i++) spi_read(16'($urandom), 4, 1'b0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
- SPI mode-0 target that emulates the external program RAM which the CPU's SPI fetch path reads from.
- Serves 0x03 READ and 0x02 WRITE commands, each followed by a 16-bit address, from an internal byte array.
- Includes a parallel load port so a bench or a host can preload the program.
- All SPI inputs are oversampled in the system clock domain; it is the target-side counterpart of the CPU's byte-fetch initiator.

Parameters:
- ADDR_W, 8, internal memory address width (2**ADDR_W bytes); SPI address bits above ADDR_W-1 are ignored.
- INIT_BYTE, 8'h77, value of every memory byte after reset (two NOP-style 4'h7 opcodes).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- spi_cs_n  input  1  chip select, active low, asynchronous to clk.
- spi_sck  input  1  SPI clock (mode 0), asynchronous to clk.
- spi_mosi  input  1  data from initiator, MSB first.
- spi_miso  output  1  data to initiator, MSB first.
- spi_miso_oe  output  1  high while MISO is actively driven.
- load_en  input  1  parallel write strobe.
- load_addr  input  ADDR_W  parallel write address.
- load_data  input  8  parallel write data.
- busy  output  1  high while chip select is asserted (synchronized).
- cmd_err  output  1  one-cycle pulse when an unsupported command byte completes.

Behaviour:
- Clocking and reset:
  - Single clock domain is clk. reset is synchronous and active-high.
  - Reset clears state to IDLE and all counters.
  - Reset output values: spi_miso=0, spi_miso_oe=0, busy=0, cmd_err=0.
  - Reset fills memory with INIT_BYTE; a loop over all entries under reset is acceptable.
  - Reset mid-transaction aborts it; any partial write byte is lost.
- Synchronization:
  - spi_sck, spi_cs_n and spi_mosi each pass through 2-flop synchronizers.
  - sck_rise and sck_fall are single-cycle pulses from a third flop on synchronized sck.
  - MOSI is sampled on sck_rise. MISO changes only on sck_fall, and also on the cycle data is first loaded.
  - Requirement on the initiator: SCK high and low phases are each at least 4 clk cycles. Faster SCK is unsupported.
- State machine:
  - IDLE: MISO not driven. A synchronized cs_n falling edge clears the bit counter and moves to CMD.
  - CMD: shift 8 MOSI bits. On the 8th rise: 0x03 goes to ADDR as a read, 0x02 goes to ADDR as a write, any other value goes to IGNORE and pulses cmd_err.
  - ADDR: shift 16 bits into addr_sr. On the 16th rise, latch addr = addr_sr[ADDR_W-1:0] and go to RDATA or WDATA.
  - RDATA:
    - On the cycle after entry, load shift_out = mem[addr] and assert spi_miso_oe.
    - Drive spi_miso = shift_out[7] before the first data rising edge.
    - Each sck_fall shifts left one bit, except on the fall that follows the 8th rise of a byte.
    - On that fall, addr increments (wrapping modulo 2**ADDR_W), shift_out reloads mem[addr+1], and bit 7 of the new byte is driven. Reads stream indefinitely.
  - WDATA: shift 8 bits. On the 8th rise write mem[addr] and increment addr with wrap. Streams indefinitely.
  - IGNORE: MISO not driven; stay until cs_n deasserts.
- Chip-select deassert: a synchronized cs_n rising edge in any state returns to IDLE the same cycle. spi_miso_oe falls to 0 and spi_miso goes to 0. A partial write byte is discarded.
- busy equals the synchronized cs_n inverted.
- Load port:
  - load_en writes mem[load_addr]=load_data at the clock edge, in any state.
  - If an SPI write commits in the same cycle, the SPI write wins regardless of address, and the load is dropped.
  - A load to the byte currently held in shift_out does not alter the byte already in flight.
- No SPI clocks while cs_n is high have any effect.

Optional Feature:
- Macro SPI_RESP_FAST_READ_EN.
- When defined: command 0x0B is FAST_READ. After the 16-bit address, the block enters state DUMMY for 8 SCK rises, ignores MOSI, and then behaves exactly as RDATA. The first data bit is driven after the fall following the 8th dummy rise.
- When undefined: 0x0B is treated as unsupported, so it pulses cmd_err and goes to IGNORE. State DUMMY does not exist.

Test Plan:
- Reset, then READ 0x03 at addr 0x0000 for 1 byte -> MISO returns 0x77; busy=1 during the transfer and 0 after cs_n rises; spi_miso_oe=0 after.
- Load port writes 0xA5 @0x10 and 0x3C @0x11; READ at 0x0010 for 2 bytes -> 0xA5 then 0x3C, each MSB first.
- WRITE 0x02 at 0x00FF with bytes 0x12, 0x34, then READ at 0x00FF for 2 bytes -> 0x12, then 0x34 from wrapped address 0x00.
- Command 0x9F -> cmd_err pulses exactly one cycle; MISO is undriven; a following READ works normally.
- WRITE at 0x0020, cs_n raised after 5 data bits -> mem[0x20] is unchanged (still 0x77); next command decodes correctly.
- SPI_RESP_FAST_READ_EN defined: 0x0B at 0x0010 (after preload 0xA5) with 8 dummy clocks -> 0xA5. Undefined: cmd_err pulses.
